// File: rtl/led_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_share_arbiter: round-robin time-sliced sharing of four LEDs           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module led_share_arbiter #(
  parameter int NREQ          = 4,
  parameter int PRESCALE_BITS = 20,
  parameter int HOLD_TICKS    = 8,
  parameter int GAP_TICKS     = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   pattern,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic                tick,
  output logic                LED1,
  output logic                LED2,
  output logic                LED3,
  output logic                LED4
);

  localparam int IDXW  = $clog2(NREQ);
  localparam int HOLDW = $clog2(HOLD_TICKS + 1);
  localparam int GAPW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_TICKS - 1);
  localparam logic [GAPW-1:0]  GAP_LAST  = GAPW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [IDXW-1:0]  LAST_RST  = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic [IDXW-1:0]          last_q, last_d;
  logic [HOLDW-1:0]         hold_q, hold_d;
  logic [GAPW-1:0]          gap_q, gap_d;
  logic [NREQ-1:0]          grant_q, grant_d;
  logic [3:0]               led_q, led_d;

  logic                     win_found;
  logic [IDXW-1:0]          win_idx;
  logic [3:0]               pat_arr [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_pat
      assign pat_arr[i] = pattern[4*i +: 4];
    end
  endgenerate

  assign tick  = &pre_q;
  assign busy  = (state_q != ST_IDLE);
  assign grant = grant_q;
  assign LED1  = led_q[0];
  assign LED2  = led_q[1];
  assign LED3  = led_q[2];
  assign LED4  = led_q[3];

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin : p_search
    int              cand;
    logic [IDXW-1:0] cidx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = cand[IDXW-1:0];
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    pre_d   = pre_q + PRESCALE_BITS'(1);
    last_d  = last_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    grant_d = '0;
    led_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_GRANT;
          last_d           = win_idx;
          hold_d           = '0;
          grant_d[win_idx] = 1'b1;
          led_d            = pat_arr[win_idx];
        end
      end
      // last_q always names the current owner while in GRANT.
      ST_GRANT: begin
        if (!req[last_q] || (tick && (hold_q == HOLD_LAST))) begin
          hold_d  = '0;
          gap_d   = '0;
          state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end else begin
          if (tick) hold_d = hold_q + HOLDW'(1);
          grant_d = grant_q;
          led_d   = pat_arr[last_q];
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = ST_IDLE;
          else                   gap_d   = gap_q + GAPW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_share_arbiter: self-checking bench for led_share_arbiter           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_led_share_arbiter;

  localparam int NREQ = 4;
  localparam int PB   = 2;
  localparam int HOLD = 3;
  localparam int GAP  = 1;
  localparam int PER  = 1 << PB;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  req   = '0;
  logic [15:0] pattern = '0;
  logic [3:0]  grant;
  logic        busy, tick, LED1, LED2, LED3, LED4;

  led_share_arbiter #(
    .NREQ(NREQ), .PRESCALE_BITS(PB), .HOLD_TICKS(HOLD), .GAP_TICKS(GAP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .pattern(pattern),
    .grant(grant), .busy(busy), .tick(tick),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner bookkeeping by whole ticks, mode 0=idle 1=owned 2=gap
  int m_pre, m_mode, m_last, m_held, m_gap;
  logic [3:0] e_grant, e_led;
  logic       e_busy, e_tick;

  function automatic logic [3:0] leds_now();
    return {LED4, LED3, LED2, LED1};
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_mode = 0; m_last = NREQ - 1; m_held = 0; m_gap = 0;
    e_grant = '0; e_led = '0; e_busy = 1'b0; e_tick = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    bit found;
    int c;
    t = (m_pre == PER - 1);
    case (m_mode)
      0: if (req != 0) begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (!found && req[c]) begin
            found = 1; m_last = c;
          end
        end
        m_mode = 1; m_held = 0;
      end
      1: begin
        if (!req[m_last] || (m_held + (t ? 1 : 0)) == HOLD) begin
          m_mode = (GAP == 0) ? 0 : 2; m_gap = 0;
        end else if (t) begin
          m_held++;
        end
      end
      default: if (t) begin
        m_gap++;
        if (m_gap == GAP) m_mode = 0;
      end
    endcase
    m_pre   = (m_pre + 1) % PER;
    e_grant = (m_mode == 1) ? 4'(1 << m_last) : 4'b0000;
    e_led   = (m_mode == 1) ? pattern[4*m_last +: 4] : 4'b0000;
    e_busy  = (m_mode != 0);
    e_tick  = (m_pre == PER - 1);
  endtask

  task automatic check_model();
    check4("grant", grant, e_grant);
    check4("leds", leds_now(), e_led);
    check1("busy", busy, e_busy);
    check1("tick", tick, e_tick);
  endtask

  // Inputs change just after a rising edge; outputs sampled 1 time unit after the next.
  task automatic cyc(input logic [3:0] r, input logic [15:0] p);
    req = r; pattern = p;
    model_step();
    @(posedge CLK); #1;
    check_model();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic mid_reset(input string name);
    #2 RST_N = 1'b0;
    #1;
    check4({name, "_grant"}, grant, 4'b0000);
    check4({name, "_leds"}, leds_now(), 4'b0000);
    check1({name, "_busy"}, busy, 1'b0);
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  grant;
    logic [3:0]  led;
    logic        busy;
    logic        tick;
  } vec_t;

  vec_t vt [11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    logic [3:0] prev;
    logic [3:0] order [$];
    int         durs [$];
    int         run;
    int         zeros;
    int         n;

    vt[0]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[1]  = '{4'b0100, 16'h0A00, 4'b0100, 4'b1010, 1'b1, 1'b0};
    vt[2]  = '{4'b0100, 16'h0600, 4'b0100, 4'b0110, 1'b1, 1'b1};
    vt[3]  = '{4'b0101, 16'h5650, 4'b0100, 4'b0110, 1'b1, 1'b0};
    vt[4]  = '{4'b0001, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vt[5]  = '{4'b0001, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vt[6]  = '{4'b0001, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vt[7]  = '{4'b0001, 16'h000F, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[8]  = '{4'b0001, 16'h000F, 4'b0001, 4'b1111, 1'b1, 1'b0};
    vt[9]  = '{4'b1001, 16'hC003, 4'b0001, 4'b0011, 1'b1, 1'b0};
    vt[10] = '{4'b1000, 16'hFFFF, 4'b0000, 4'b0000, 1'b1, 1'b1};

    // Reset with all requesting, then first grant to requester 0
    req = 4'b1111; pattern = 16'h4321;
    #2;
    check4("rst_grant", grant, 4'b0000);
    check4("rst_leds", leds_now(), 4'b0000);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tick", tick, 1'b0);
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cyc(4'b1111, 16'h4321);
    check4("rst_first_grant", grant, 4'b0001);
    check4("rst_first_leds", leds_now(), 4'b0001);

    // Hand-derived vector table from a fresh reset
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = vt[i].req; pattern = vt[i].pat;
      model_step();
      @(posedge CLK); #1;
      check4($sformatf("vec%0d_grant", i), grant, vt[i].grant);
      check4($sformatf("vec%0d_leds", i), leds_now(), vt[i].led);
      check1($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      check1($sformatf("vec%0d_tick", i), tick, vt[i].tick);
    end

    // Single requester: expiry, one-tick gap, re-grant
    do_reset();
    cyc(4'b0100, 16'h0A00);
    check4("single_grant", grant, 4'b0100);
    check4("single_leds", leds_now(), 4'b1010);
    run = 1;
    n = 0;
    while (grant != 0 && n < 40) begin cyc(4'b0100, 16'h0A00); if (grant != 0) run++; n++; end
    check_range("single_hold_cycles", run, (HOLD-1)*PER+1, HOLD*PER);
    zeros = 0;
    n = 0;
    while (grant == 0 && n < 40) begin
      check4("single_gap_leds", leds_now(), 4'b0000);
      cyc(4'b0100, 16'h0A00); zeros++; n++;
    end
    check_range("single_gap_cycles", zeros, 2, PER + 1);
    check4("single_regrant", grant, 4'b0100);

    // Round-robin rotation with 1011 held
    do_reset();
    prev = '0; run = 0; n = 0;
    while (order.size() < 4 && n < 200) begin
      cyc(4'b1011, 16'($urandom));
      if (grant != 0 && prev == 0) order.push_back(grant);
      if (grant != 0) run++;
      else if (prev != 0) begin durs.push_back(run); run = 0; end
      prev = grant;
      n++;
    end
    check_range("rr_grant_count", order.size(), 4, 4);
    if (order.size() == 4) begin
      check4("rr_order0", order[0], 4'b0001);
      check4("rr_order1", order[1], 4'b0010);
      check4("rr_order2", order[2], 4'b1000);
      check4("rr_order3", order[3], 4'b0001);
    end
    for (int i = 0; i < durs.size() && i < 3; i++)
      check_range($sformatf("rr_dur%0d", i), durs[i], (HOLD-1)*PER+1, HOLD*PER);

    // Early release by requester 1, requester 2 joins mid-slice
    do_reset();
    cyc(4'b0010, 16'h0050);
    cyc(4'b0110, 16'h0C50);
    cyc(4'b0110, 16'h0C50);
    cyc(4'b0100, 16'h0C50);
    check4("early_grant", grant, 4'b0000);
    check4("early_leds", leds_now(), 4'b0000);
    check1("early_busy", busy, 1'b1);
    n = 0;
    while (grant == 0 && n < 20) begin cyc(4'b0100, 16'h0C50); n++; end
    check4("early_next", grant, 4'b0100);
    check4("early_next_leds", leds_now(), 4'b1100);

    // Owner drops req on the same cycle as its final tick
    do_reset();
    cyc(4'b0011, 16'h0021);
    n = 0;
    while (!(m_mode == 1 && m_held == HOLD - 1 && m_pre == PER - 1) && n < 20) begin
      cyc(4'b0011, 16'h0021); n++;
    end
    cyc(4'b0010, 16'h0021);
    check4("sim_grant", grant, 4'b0000);
    check1("sim_busy", busy, 1'b1);
    zeros = 1; n = 0;
    while (grant == 0 && n < 20) begin cyc(4'b0010, 16'h0021); if (grant == 0) zeros++; n++; end
    check_range("sim_zero_cycles", zeros, PER + 1, PER + 1);
    check4("sim_next", grant, 4'b0010);

    // Asynchronous reset while owned
    do_reset();
    cyc(4'b0100, 16'h0F00);
    cyc(4'b0100, 16'h0F00);
    mid_reset("async");
    cyc(4'b1111, 16'h0F0A);
    check4("async_first", grant, 4'b0001);

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(0, 5) == 0) r = 4'($urandom);
      cyc(r, 16'($urandom));
      if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_share_arbiter.md
# led_share_arbiter

Round-robin arbiter that shares the four board LEDs between several pattern sources. A free-running prescaler counts time slices. Each requester holds the LEDs for a bounded number of slices. A short blank gap separates consecutive owners. The block sits between pattern producers (counters, status logic) and the top-level LED pins.

## Interface

Parameters:
- `NREQ`, 4: number of requesters; legal values are 2 to 8.
- `PRESCALE_BITS`, 20: prescaler width; a tick occurs every 2^PRESCALE_BITS clock cycles.
- `HOLD_TICKS`, 8: maximum ticks one owner keeps the LEDs; must be at least 1.
- `GAP_TICKS`, 1: ticks of blank output between owners; 0 means no gap.

Ports:
- `CLK`  in  1  system clock; one clock domain only.
- `RST_N`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; level, held while the requester wants the LEDs.
- `pattern`  in  4*NREQ  requester i's LED pattern in bits [4i+3:4i]; bit 0 drives LED1.
- `grant`  out  NREQ  one-hot registered grant; all zeros when no owner.
- `busy`  out  1  high whenever the state is not IDLE.
- `tick`  out  1  one-cycle prescaler pulse, exported for test and debug.
- `LED1`..`LED4`  out  1 each  registered LED drive.

## Operation

- Prescaler:
  - Free-running `PRESCALE_BITS` counter, reset to 0, wraps naturally.
  - `tick` is high in the cycle the counter equals all-ones.
  - It runs independently of arbiter state and is never restarted.
- Round-robin pointer `last`:
  - Reset value is NREQ-1, so the first grant after reset goes to requester 0.
  - Priority search starts at `last`+1 modulo NREQ.
  - `last` is updated to the winner when a grant is issued.
- IDLE:
  - `grant`=0, LEDs=0.
  - If any `req` bit is high, pick the winner, set `grant`, clear the hold counter, and go to GRANT.
  - This does not wait for a tick.
- GRANT:
  - LEDs register the owner's `pattern` slice every cycle, so the display is live.
  - The hold counter (width clog2(HOLD_TICKS+1)) increments on each tick.
  - Leave to GAP when the owner's `req` is low, or when a tick brings the hold count to HOLD_TICKS, whichever comes first.
  - On leaving, `grant` and LEDs clear in the same registered update.
- GAP:
  - `grant`=0, LEDs=0, gap counter cleared on entry.
  - Go to IDLE after GAP_TICKS ticks.
  - If GAP_TICKS=0, GRANT goes straight to IDLE and GAP is never entered.
- Boundary conditions:
  - Owner drops `req` on the same cycle as the final tick: a single exit to GAP, no double count.
  - Owner still requesting at expiry: it loses the LEDs. It regains them only after every other active requester has been served in round-robin order. If it is the only requester, it regains them after the gap.
  - Non-owner `req` changes during GRANT or GAP: ignored until IDLE.
  - `pattern` of non-owners is never visible on the LEDs.
  - `RST_N` low at any time: state returns to IDLE, and all outputs, counters and `last` return to reset values immediately (asynchronous). Release is synchronous to `CLK`.
- Outputs: `grant` is always one-hot or zero; never more than one bit is set.

## Timing

- Reset values: `grant`=0, `busy`=0, `tick`=0, LED1..LED4=0.
- Arbitration latency:
  - `req` high in IDLE at cycle t gives `grant` and `busy` high at t+1.
  - LEDs show that cycle's `pattern` at t+1.
- Display latency: `pattern` change at cycle t appears on the LEDs at t+1 while in GRANT.
- Early release:
  - Owner `req` low at cycle t gives `grant`=0 and LEDs=0 at t+1.
  - `busy` stays high through GAP.
- Expiry:
  - Tick number HOLD_TICKS counted in GRANT at cycle t gives `grant`=0 at t+1.
  - Total ownership is between (HOLD_TICKS-1)·2^P+1 and HOLD_TICKS·2^P cycles.
- IDLE to re-grant: requesters are re-evaluated in the first IDLE cycle, so the new grant appears one cycle after IDLE is entered.

## Test plan

Bench configuration: PRESCALE_BITS=2 (tick every 4 cycles), HOLD_TICKS=3, GAP_TICKS=1, NREQ=4.

- Reset check: assert `RST_N`=0 with `req`=4'b1111 → `grant`=0, LEDs=0, `busy`=0. Release → `grant`=4'b0001 one cycle later.
- Single requester: `req`=4'b0100, pattern[11:8]=4'b1010 → `grant`=4'b0100, LED4..LED1=1010 one cycle later. `grant` drops after the 3rd tick. LEDs are 0 for one tick of gap, then `grant`=4'b0100 again.
- Round-robin rotation: `req`=4'b1011 held → grants in the order 0001, 0010, 1000, 0001, each lasting 3 ticks, with gaps between them.
- Early release: requester 1 drops `req` mid-slice at cycle t → `grant`=0 and LEDs=0 at t+1, then GAP, then the next requester is granted.
- Simultaneous release and expiry: owner `req` falls on the 3rd tick cycle → exactly one gap. The hold counter does not wrap, and `grant` stays one-hot.
- Async reset mid-GRANT: pull `RST_N` low between clock edges → outputs clear before the next edge. After release, the first grant goes to requester 0.
